adder_share_sched: RTL and testbench
====================================

Name: adder_share_sched

Overview:
- Shares one narrow W-bit adder slice between two requesters.
- Each accepted request is an N-bit add, computed serially over N/W slice cycles, least-significant slice first.
- The block returns an (N+1)-bit sum and the id of the requester that issued it.
- It sits between lab datapath clients and the structural adder cells, replacing a full-width adder per client.

Parameters:
- N, 32, operand width; N must be a multiple of W.
- W, 8, slice width; one slice is processed per cycle.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- a0  in  N  requester 0 operand A.
- b0  in  N  requester 0 operand B.
- valid0  in  1  requester 0 request pending.
- ready0  out  1  requester 0 request accepted this cycle.
- a1  in  N  requester 1 operand A.
- b1  in  N  requester 1 operand B.
- valid1  in  1  requester 1 request pending.
- ready1  out  1  requester 1 request accepted this cycle.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- resp_id  out  1  requester id of the result.
- resp_sum  out  N+1  a+b; bit N is the final carry.

Behaviour:
- Reset (reset_n=0 at an edge):
  - state=IDLE; resp_valid=0, resp_sum=0, resp_id=0.
  - Slice index=0, carry=0.
  - last_grant=1, so requester 0 wins the first contention.
  - Reset mid-RUN or in DONE abandons the operation; no response is produced.
- ready0/ready1 are combinational from state and registers:
  - Asserted only in IDLE, at most one at a time.
  - Never asserted while reset_n=0.
- IDLE:
  - Only valid0 → grant 0. Only valid1 → grant 1.
  - Both valid → grant the requester not equal to last_grant.
  - Granted ready is high. On that edge the block latches a, b and id, sets last_grant=id, index=0, carry=0, and goes to RUN.
  - No valid → stay in IDLE.
- RUN, one slice per edge:
  - Slice k: {c,s} = a[kW+W-1:kW] + b[kW+W-1:kW] + carry.
  - s is written to sum[kW+W-1:kW]; carry=c; k increments.
  - At k=N/W-1: sum[N]=c, go to DONE.
  - RUN lasts exactly N/W cycles.
  - Slice arithmetic uses full-adder cells (structural), not an N-bit '+'.
- DONE:
  - resp_valid=1; resp_sum and resp_id are stable.
  - On an edge with resp_ready=1: resp_valid=0 and go to IDLE.
  - If resp_ready is already high, DONE lasts 1 cycle.
- Latency: resp_valid rises N/W edges after the acceptance edge (4 for defaults).
- Throughput: at most one request per N/W+2 cycles; the next grant happens in IDLE after DONE.
- Operands changing after acceptance do not affect the in-flight result.
- A requester keeps valid high until it sees ready. Dropping valid before a grant is legal; it just loses its turn.
- Round-robin applies only under contention. A lone requester is served back-to-back.
- resp_sum keeps its last value after the DONE→IDLE handoff; only resp_valid qualifies it.
- Wrap-around: the carry chain spans all slices. Max inputs give sum = 2^(N+1)-2 with bit N=1.

Test Plan:
- Single request:
  - valid0=1, a0=1000, b0=1000.
  - Expect ready0 for 1 cycle, then resp_valid 4 edges later with resp_sum=2000, resp_id=0, ready1 never high.
- Carry propagation:
  - a1=32'hFFFF_FFFF, b1=1.
  - Expect resp_sum=33'h1_0000_0000, resp_id=1.
  - Then a0=b0=32'hFFFF_FFFF → 33'h1_FFFF_FFFE.
- Contention:
  - valid0=valid1=1 held, a0=2000,b0=1000 / a1=3000,b1=1000, resp_ready=1.
  - Expect grants alternating 0,1,0,1 with results 3000, 4000, 3000, 4000 and matching resp_id.
- Backpressure:
  - resp_ready=0 for 10 cycles after resp_valid.
  - Expect resp_valid and resp_sum held, and no ready0/ready1 during the hold.
  - Raise resp_ready: one cycle later resp_valid=0, then a new grant.
- Reset mid-RUN:
  - Pull reset_n low on the 2nd RUN cycle for one edge.
  - Expect resp_valid=0 and resp_sum=0 with no response.
  - The next contention grants requester 0 first.
- Operand change after accept:
  - Change a0 to 5 the cycle after ready0.
  - Expect resp_sum to reflect the latched original operands.

Source files
------------

// File: rtl/adder_share_sched.sv
// adder_share_sched: one W-bit ripple slice shared by two requesters.
// An accepted N-bit add is computed over N/W cycles, LSB slice first,
// and returned as an (N+1)-bit sum tagged with the requester id.

// Single full-adder cell; the slice is a ripple chain of these.
module adder_share_sched_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p_s;

  assign p_s = a ^ b;
  assign s   = p_s ^ ci;
  assign co  = (a & b) | (ci & p_s);

endmodule

module adder_share_sched #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] b0,
  input  logic         valid0,
  output logic         ready0,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b1,
  input  logic         valid1,
  output logic         ready1,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [N:0]   resp_sum
);

  localparam int NS = N / W;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;

  // Operands are shifted right one slice per RUN cycle so the active
  // slice always sits in the low W bits.
  logic [N-1:0]    a_r;
  logic [N-1:0]    b_r;
  logic            id_r;
  logic            last_grant_r;
  logic [IW-1:0]   idx_r;
  logic            carry_r;
  logic [N:0]      sum_r;
  logic            resp_valid_r;

  logic            grant_vld_s;
  logic            grant_id_s;
  logic            last_slice_s;
  logic [W-1:0]    slice_sum_s;
  logic [W:0]      chain_s;

  assign last_slice_s = (idx_r == IW'(NS - 1));

  // Round-robin arbiter: only in IDLE and never while reset is asserted.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = 1'b0;
    if (reset_n && (state_r == ST_IDLE)) begin
      if (valid0 && valid1) begin
        grant_vld_s = 1'b1;
        grant_id_s  = ~last_grant_r;
      end else if (valid0) begin
        grant_vld_s = 1'b1;
        grant_id_s  = 1'b0;
      end else if (valid1) begin
        grant_vld_s = 1'b1;
        grant_id_s  = 1'b1;
      end else begin
        grant_vld_s = 1'b0;
        grant_id_s  = 1'b0;
      end
    end else begin
      grant_vld_s = 1'b0;
      grant_id_s  = 1'b0;
    end
  end

  assign ready0 = grant_vld_s & ~grant_id_s;
  assign ready1 = grant_vld_s &  grant_id_s;

  // Structural W-bit ripple slice fed by the latched carry.
  assign chain_s[0] = carry_r;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_fa
      adder_share_sched_fa u_fa (
        .a  (a_r[gi]),
        .b  (b_r[gi]),
        .ci (chain_s[gi]),
        .s  (slice_sum_s[gi]),
        .co (chain_s[gi+1])
      );
    end
  endgenerate

  // Next-state decode for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_vld_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_slice_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (resp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath: latch the granted request, step one slice per RUN cycle,
  // and hold the response until the consumer takes it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      a_r          <= '0;
      b_r          <= '0;
      id_r         <= 1'b0;
      last_grant_r <= 1'b1;
      idx_r        <= '0;
      carry_r      <= 1'b0;
      sum_r        <= '0;
      resp_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_vld_s) begin
            a_r          <= grant_id_s ? a1 : a0;
            b_r          <= grant_id_s ? b1 : b0;
            id_r         <= grant_id_s;
            last_grant_r <= grant_id_s;
            idx_r        <= '0;
            carry_r      <= 1'b0;
          end
        end
        ST_RUN: begin
          for (int k = 0; k < NS; k++) begin
            if (idx_r == IW'(k)) begin
              sum_r[k*W +: W] <= slice_sum_s;
            end
          end
          a_r     <= a_r >> W;
          b_r     <= b_r >> W;
          carry_r <= chain_s[W];
          if (last_slice_s) begin
            sum_r[N]     <= chain_s[W];
            idx_r        <= '0;
            resp_valid_r <= 1'b1;
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
          end
        end
        default: begin
          resp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_r;
  assign resp_id    = id_r;
  assign resp_sum   = sum_r;

endmodule

// File: tb/tb_adder_share_sched.sv
// Self-checking bench for adder_share_sched (N=32, W=8).
// Expected responses are queued when a grant is seen and compared when
// the DUT hands a result over.
module tb_adder_share_sched;

  logic        clock;
  logic        reset_n;
  logic [31:0] a0, b0, a1, b1;
  logic        valid0, valid1;
  logic        ready0, ready1;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [32:0] resp_sum;

  adder_share_sched #(.N(32), .W(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .a0         (a0),
    .b0         (b0),
    .valid0     (valid0),
    .ready0     (ready0),
    .a1         (a1),
    .b1         (b1),
    .valid1     (valid1),
    .ready1     (ready1),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum)
  );

  typedef struct packed {
    logic        id;
    logic [32:0] sum;
  } exp_t;

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] sum;
  } vec_t;

  int   checks;
  int   errors;
  bit   mon_en;
  bit   model_last;
  exp_t q[$];
  exp_t mon_e;
  vec_t tbl[8];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: mutual exclusion of readies and every handed-over result.
  always @(negedge clock) begin
    if (mon_en) begin
      chk("ready_mutex", {63'd0, ready0 & ready1}, 64'd0);
      if (resp_valid && resp_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp actual id=%0d sum=%0h expected none", resp_id, resp_sum);
        end else begin
          mon_e = q.pop_front();
          chk("resp_id", {63'd0, resp_id}, {63'd0, mon_e.id});
          chk("resp_sum", {31'd0, resp_sum}, {31'd0, mon_e.sum});
        end
      end
    end
  end

  task automatic wait_drain();
    for (int c = 0; c < 60 && q.size() != 0; c++) @(negedge clock);
    chk("drain_pending", q.size(), 64'd0);
  endtask

  // Drive one request, wait for its grant, optionally queue the expected
  // result and measure latency; post_a replaces the operand after acceptance.
  task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b,
                       input logic [32:0] exp, input bit push, input bit chk_lat,
                       input logic [31:0] post_a);
    bit got;
    bit rdy_seen;
    int lat;
    @(posedge clock); #1;
    if (id == 1'b0) begin a0 = a; b0 = b; valid0 = 1'b1; end
    else begin a1 = a; b1 = b; valid1 = 1'b1; end
    got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clock);
      if (id ? ready1 : ready0) got = 1'b1;
    end
    chk("grant_seen", {63'd0, got}, 64'd1);
    if (got) begin
      chk("other_ready", {63'd0, id ? ready0 : ready1}, 64'd0);
      if (push) q.push_back('{id: id, sum: exp});
      model_last = id;
    end
    @(posedge clock); #1;
    if (id == 1'b0) begin valid0 = 1'b0; a0 = post_a; end
    else begin valid1 = 1'b0; a1 = post_a; end
    if (chk_lat && got) begin
      @(negedge clock);
      chk("ready_one_cycle", {62'd0, ready0, ready1}, 64'd0);
      rdy_seen = 1'b0;
      lat = 0;
      for (int e = 1; e <= 20 && lat == 0; e++) begin
        @(posedge clock);
        @(negedge clock);
        if (ready0 || ready1) rdy_seen = 1'b1;
        if (resp_valid) lat = e;
      end
      chk("latency_edges", lat, 64'd4);
      chk("ready_during_op", {63'd0, rdy_seen}, 64'd0);
    end
  endtask

  // Both requesters held valid: grants must alternate starting from ~last.
  task automatic contend(input int n);
    bit got;
    bit exp_id;
    @(posedge clock); #1;
    a0 = 32'd2000; b0 = 32'd1000; a1 = 32'd3000; b1 = 32'd1000;
    valid0 = 1'b1; valid1 = 1'b1;
    for (int g = 0; g < n; g++) begin
      got = 1'b0;
      exp_id = ~model_last;
      for (int c = 0; c < 30 && !got; c++) begin
        @(negedge clock);
        if (ready0 || ready1) got = 1'b1;
      end
      chk("contend_grant_seen", {63'd0, got}, 64'd1);
      if (got) begin
        chk("contend_ready0", {63'd0, ready0}, {63'd0, ~exp_id});
        chk("contend_ready1", {63'd0, ready1}, {63'd0, exp_id});
        q.push_back('{id: exp_id, sum: (exp_id ? 33'd4000 : 33'd3000)});
        model_last = exp_id;
      end
    end
    @(posedge clock); #1;
    valid0 = 1'b0; valid1 = 1'b0;
    wait_drain();
  endtask

  initial begin
    bit got;
    bit bad;

    checks = 0; errors = 0; mon_en = 1'b0; model_last = 1'b1;
    tbl[0] = '{1'b0, 32'd1000,        32'd1000,        33'd2000};
    tbl[1] = '{1'b1, 32'hFFFF_FFFF,   32'd1,           33'h1_0000_0000};
    tbl[2] = '{1'b0, 32'hFFFF_FFFF,   32'hFFFF_FFFF,   33'h1_FFFF_FFFE};
    tbl[3] = '{1'b1, 32'd0,           32'd0,           33'd0};
    tbl[4] = '{1'b0, 32'h00FF_00FF,   32'h0001_FF01,   33'h0_0101_0000};
    tbl[5] = '{1'b1, 32'h8000_0000,   32'h8000_0000,   33'h1_0000_0000};
    tbl[6] = '{1'b0, 32'h1234_5678,   32'h1111_1111,   33'h0_2345_6789};
    tbl[7] = '{1'b1, 32'h7FFF_FFFF,   32'd1,           33'h0_8000_0000};

    // Reset with both requesters pending: no ready may be seen.
    reset_n = 1'b0; resp_ready = 1'b1;
    a0 = 32'd1; b0 = 32'd1; a1 = 32'd2; b1 = 32'd2;
    valid0 = 1'b1; valid1 = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", {62'd0, ready0, ready1}, 64'd0);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_sum", {31'd0, resp_sum}, 64'd0);
    chk("rst_resp_id", {63'd0, resp_id}, 64'd0);
    valid0 = 1'b0; valid1 = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    model_last = 1'b1;
    mon_en = 1'b1;

    // Lone requests, back to back; the first also checks latency.
    for (int i = 0; i < 8; i++) begin
      issue(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].sum, 1'b1, (i == 0), tbl[i].a);
    end
    wait_drain();

    // Contention: 0,1,0,1.
    contend(4);

    // Backpressure: result held for 10 cycles, no grants meanwhile.
    resp_ready = 1'b0;
    issue(1'b1, 32'd3000, 32'd1000, 33'd4000, 1'b1, 1'b0, 32'd3000);
    a0 = 32'd7; b0 = 32'd8; valid0 = 1'b1;
    got = 1'b0; bad = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clock);
      if (ready0 || ready1) bad = 1'b1;
      if (resp_valid) got = 1'b1;
    end
    chk("bp_resp_seen", {63'd0, got}, 64'd1);
    chk("bp_ready_in_run", {63'd0, bad}, 64'd0);
    repeat (10) begin
      @(negedge clock);
      chk("bp_hold_valid", {63'd0, resp_valid}, 64'd1);
      chk("bp_hold_sum", {31'd0, resp_sum}, 64'd4000);
      chk("bp_hold_id", {63'd0, resp_id}, 64'd1);
      chk("bp_hold_ready", {62'd0, ready0, ready1}, 64'd0);
    end
    @(posedge clock); #1;
    resp_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("bp_valid_drop", {63'd0, resp_valid}, 64'd0);
    chk("bp_next_grant", {62'd0, ready0, ready1}, 64'd2);
    if (ready0) begin
      q.push_back('{id: 1'b0, sum: 33'd15});
      model_last = 1'b0;
    end
    @(posedge clock); #1;
    valid0 = 1'b0;
    wait_drain();

    // Operand change right after acceptance must not affect the result.
    issue(1'b0, 32'd100, 32'd23, 33'd123, 1'b1, 1'b0, 32'd5);
    wait_drain();

    // Reset on the second RUN cycle abandons the operation.
    @(posedge clock); #1;
    a0 = 32'd11; b0 = 32'd22; valid0 = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clock);
      if (ready0) got = 1'b1;
    end
    chk("rr_grant_seen", {63'd0, got}, 64'd1);
    model_last = 1'b0;
    @(posedge clock); #1;
    valid0 = 1'b0; a1 = 32'd1; b1 = 32'd2; valid1 = 1'b1;
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(negedge clock);
    chk("rr_ready_in_reset", {62'd0, ready0, ready1}, 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1; valid1 = 1'b0;
    model_last = 1'b1;
    @(negedge clock);
    chk("rr_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rr_resp_sum", {31'd0, resp_sum}, 64'd0);
    bad = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (resp_valid) bad = 1'b1;
    end
    chk("rr_no_response", {63'd0, bad}, 64'd0);

    // After reset, requester 0 wins the first contention.
    contend(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global bound in case a wait above never completes.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
